channel_param_sequencer: RTL
============================

// Module: channel_param_sequencer
// PURPOSE
//  Sequences run-time configuration of one uberClock signal channel (NCO, down/up-conversion CORDICs, gain stage).
//  Host (CSR bridge) writes phase_inc_nco, phase_inc_down and gain into shadow registers; a commit applies them
//  atomically on a decimated-sample boundary (downsampler ce strobe). Gain is ramped linearly to the new target to
//  avoid DAC steps. Outputs drive the channel's phase_inc_nco / phase_inc_down / gain inputs directly.
// PARAMETERS
//  PW         19          phase increment width (matches channel phase accumulator)
//  GW         32          gain width; unity gain = 1<<30 (channel applies >>>30)
//  GAIN_STEP  32'h0010_0000  gain change per tick while ramping (unity in 1024 ticks)
//  RAMP_EN    1           1: ramp gain; 0: gain jumps to target at apply
// PORTS
//  sys_clk         in   1    system clock, single domain
//  rst_n           in   1    asynchronous reset, active low
//  cfg_valid       in   1    shadow write request
//  cfg_ready       out  1    shadow write accepted when cfg_valid&cfg_ready
//  cfg_addr        in   2    0=phase_inc_nco 1=phase_inc_down 2=gain 3=reserved
//  cfg_data        in   32   write data; addr0/1 use [PW-1:0], addr2 uses [GW-1:0]
//  commit          in   1    1-cycle request to apply shadows
//  tick            in   1    decimated-sample strobe (downsampler ce_out)
//  phase_inc_nco   out  PW   active NCO increment
//  phase_inc_down  out  PW   active down/up-conversion increment
//  gain            out  GW   active (ramped) gain
//  busy            out  1    state != IDLE
//  update_pulse    out  1    1-cycle pulse when phase increments/gain target applied
//  commit_err      out  1    1-cycle pulse when commit dropped (not IDLE)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all shadows, phase_inc_*, gain, target = 0; state IDLE; cfg_ready=1; busy,
//    update_pulse, commit_err = 0. Reset mid-ramp/mid-arm aborts immediately; no pending commit survives.
//  - cfg_ready = (state != ARMED). Accepted write updates shadow on next edge; addr3 accepted, discarded.
//    Writes in IDLE/RAMP touch shadows only, never active outputs.
//  - FSM IDLE -> ARMED on commit (same-cycle cfg write lands in shadow and is included). tick in the commit
//    cycle is NOT consumed; apply waits for the next tick.
//  - ARMED: shadows frozen (cfg_ready=0). On tick: registered outputs update on that edge, so new values are
//    visible the cycle after tick is sampled high; phase_inc_* <= shadows, target <= gain shadow, update_pulse=1
//    that cycle. If RAMP_EN=0 or target==gain: gain <= target, -> IDLE; else -> RAMP.
//  - RAMP: each tick, if |target-gain| <= GAIN_STEP gain <= target and -> IDLE, else gain +/- GAIN_STEP toward
//    target. Unsigned arithmetic in GW+1 bits; never overshoots, never wraps. First step on first tick after apply.
//  - commit while ARMED or RAMP: ignored, commit_err=1 for one cycle; active state unchanged.
//  - ticks in IDLE ignored. Outputs constant between ticks.
//  - busy = 1 in ARMED and RAMP; falls the cycle gain reaches target.
// TESTING
//  1 Assert rst_n=0 mid-operation -> all outputs 0, cfg_ready=1, busy=0 without waiting for clock edge.
//  2 Write a0=0x01000, a1=0x02000, commit, tick 5 cycles later -> phase_inc_nco=0x01000, phase_inc_down=0x02000
//    the cycle after tick, update_pulse one cycle high, unchanged before tick.
//  3 Gain 0 -> 0x4000_0000, GAIN_STEP default -> 1024 ticks, gain monotonic +0x10_0000/tick, ends exactly
//    0x4000_0000, busy drops that cycle.
//  4 Gain 0x4000_0000 -> 5 -> down-ramp, last step clamps to exactly 5; RAMP_EN=0 build jumps in 1 tick.
//  5 commit during RAMP -> commit_err pulse, ramp continues; cfg_valid held in ARMED -> cfg_ready=0 until apply,
//    write lands after; commit+tick same cycle -> apply only on following tick.
//  6 Write addr3=0xFFFF_FFFF then commit -> no output other than update_pulse changes.

Source files
------------

// File: rtl/channel_param_sequencer.sv
// channel_param_sequencer: shadowed channel config (NCO/down increments, gain) applied atomically on a tick, gain ramped to target
// Ports: sys_clk/rst_n clock and async active-low reset; cfg_valid/cfg_ready/cfg_addr/cfg_data shadow write port
//        (0=nco, 1=down, 2=gain, 3=discarded); commit arms an apply on the next tick; tick is the decimated-sample strobe;
//        phase_inc_nco/phase_inc_down/gain active outputs; busy while armed or ramping; update_pulse on apply;
//        commit_err when a commit arrives while armed or ramping.
module channel_param_sequencer #(
  parameter int PW = 19,
  parameter int GW = 32,
  parameter logic [GW-1:0] GAIN_STEP = 32'h0010_0000,
  parameter bit RAMP_EN = 1'b1
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_addr,
  input  logic [31:0]   cfg_data,
  input  logic          commit,
  input  logic          tick,
  output logic [PW-1:0] phase_inc_nco,
  output logic [PW-1:0] phase_inc_down,
  output logic [GW-1:0] gain,
  output logic          busy,
  output logic          update_pulse,
  output logic          commit_err
);
  typedef enum logic [1:0] {IDLE, ARMED, RAMP} state_t;
  state_t        r_state;
  logic [PW-1:0] r_sh_nco, r_sh_down;
  logic [GW-1:0] r_sh_gain, r_target;
  logic          w_wr, w_up, w_close;
  logic [GW:0]   w_diff;
  assign cfg_ready = r_state != ARMED;
  assign busy      = r_state != IDLE;
  assign w_wr      = cfg_valid && cfg_ready;
  assign w_up      = r_target > gain;
  // distance to target in GW+1 bits so the last step can clamp instead of wrapping
  assign w_diff    = w_up ? {1'b0, r_target} - {1'b0, gain} : {1'b0, gain} - {1'b0, r_target};
  assign w_close   = w_diff <= {1'b0, GAIN_STEP};
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_sh_nco       <= '0;
      r_sh_down      <= '0;
      r_sh_gain      <= '0;
      r_target       <= '0;
      phase_inc_nco  <= '0;
      phase_inc_down <= '0;
      gain           <= '0;
      update_pulse   <= 1'b0;
      commit_err     <= 1'b0;
    end else begin
      update_pulse <= 1'b0;
      commit_err   <= 1'b0;
      if (w_wr && cfg_addr == 2'd0) r_sh_nco  <= cfg_data[PW-1:0];
      if (w_wr && cfg_addr == 2'd1) r_sh_down <= cfg_data[PW-1:0];
      if (w_wr && cfg_addr == 2'd2) r_sh_gain <= cfg_data[GW-1:0];
      case (r_state)
        IDLE: if (commit) r_state <= ARMED;
        ARMED: begin
          if (commit) commit_err <= 1'b1;
          if (tick) begin
            phase_inc_nco  <= r_sh_nco;
            phase_inc_down <= r_sh_down;
            r_target       <= r_sh_gain;
            update_pulse   <= 1'b1;
            if (!RAMP_EN || r_sh_gain == gain) begin
              gain    <= r_sh_gain;
              r_state <= IDLE;
            end else r_state <= RAMP;
          end
        end
        RAMP: begin
          if (commit) commit_err <= 1'b1;
          if (tick) begin
            gain    <= w_close ? r_target : w_up ? gain + GAIN_STEP : gain - GAIN_STEP;
            r_state <= w_close ? IDLE : RAMP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
